// File: rtl/i2c_codec_slave_if.sv
// ---------------------------------------------------------------------------
// i2c_codec_slave_if
// Host-side signal bundle of the I2C codec target: the register-commit
// strobe, the register file readback port and the bus status flags.
//   wr_valid  slave->host  one-cycle pulse when a register write commits
//   wr_addr   slave->host  register address of the last commit (7 bits)
//   wr_data   slave->host  data of the last commit (9 bits)
//   rd_addr   host->slave  register file read address (4 bits)
//   rd_data   slave->host  reg[rd_addr], combinational (9 bits)
//   busy      slave->host  high from START until STOP
//   err       slave->host  one-cycle pulse on protocol / register address error
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface i2c_codec_slave_if;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [3:0] rd_addr;
    logic [8:0] rd_data;
    logic       busy;
    logic       err;

    modport slave  (output wr_valid, wr_addr, wr_data, rd_data, busy, err,
                    input  rd_addr);
    modport master (input  wr_valid, wr_addr, wr_data, rd_data, busy, err,
                    output rd_addr);
endinterface

// File: rtl/i2c_codec_slave.sv
// ---------------------------------------------------------------------------
// i2c_codec_slave
// I2C target for 3-byte codec writes {dev_addr+W, sub_addr, data}. SCL/SDA
// are oversampled on clk; each 16-bit word {reg_addr[6:0], reg_data[8:0]}
// is written into an internal register file that the host can read back.
// Writing RESET_REG clears the whole register file.
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset (also releases SDA at once)
//   i2c_sclk  bus clock from the master
//   i2c_sdat  open-drain data line, driven 1'b0 or 1'bz only
//   host      i2c_codec_slave_if.slave: commit strobe, readback, busy, err
// Build option:
//   I2C_SLV_FILTER_EN  adds a 3-sample majority filter on SCL and SDA after
//                      the synchronisers (rejects 1-clk pulses, +2 cycles).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module i2c_codec_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
    parameter int         NUM_REGS    = 10,
    parameter logic [6:0] RESET_REG   = 7'h0F,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i2c_sclk,
    inout  wire               i2c_sdat,
    i2c_codec_slave_if.slave  host
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, SUB, ACK_S, DATA, ACK_D, IGNORE
    } state_t;

    localparam logic [7:0] WR_BYTE = {SLAVE_ADDR, 1'b0};

    // Synchronisers; an idle bus is high so they reset to 1.
    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_s, sda_s, scl_f, sda_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i2c_sclk};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i2c_sdat};
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

`ifdef I2C_SLV_FILTER_EN
    // Majority of the current and two previous samples, registered: a level
    // must persist for 2 clks to pass, at the cost of 2 cycles of latency.
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_flt_q, sda_flt_q;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_flt_q  <= 1'b1;
            sda_flt_q  <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_s};
            sda_hist_q <= {sda_hist_q[0], sda_s};
            scl_flt_q  <= maj3(scl_s, scl_hist_q[0], scl_hist_q[1]);
            sda_flt_q  <= maj3(sda_s, sda_hist_q[0], sda_hist_q[1]);
        end
    end

    assign scl_f = scl_flt_q;
    assign sda_f = sda_flt_q;
`else
    assign scl_f = scl_s;
    assign sda_f = sda_s;
`endif

    // Bus event detection on the cleaned-up signals.
    logic scl_prev_q, sda_prev_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  = scl_f & ~scl_prev_q;
    assign scl_fall  = ~scl_f & scl_prev_q;
    assign start_det = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
    assign stop_det  = scl_f & scl_prev_q & ~sda_prev_q & sda_f;

    // FSM, byte shifter, output registers and register file.
    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q, sub_q;
    logic       sda_drv_q, busy_q, wr_valid_q, err_q;
    logic [6:0] wr_addr_q;
    logic [8:0] wr_data_q;
    logic [8:0] regs_q [NUM_REGS];

    logic [7:0] shift_d;
    logic [6:0] word_addr_d;
    logic [8:0] word_data_d;
    logic       commit_ok_d;

    // The byte as it will stand once the current bit is shifted in.
    assign shift_d     = {shift_q[6:0], sda_f};
    assign word_addr_d = sub_q[7:1];
    assign word_data_d = {sub_q[0], shift_d};
    assign commit_ok_d = (int'(word_addr_d) < NUM_REGS) || (word_addr_d == RESET_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            sub_q      <= 8'h00;
            sda_drv_q  <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;
            wr_addr_q  <= 7'h00;
            wr_data_q  <= 9'h000;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 9'h000;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
            wr_valid_q <= 1'b0;
            err_q      <= 1'b0;

            // STOP beats START beats bit sampling; a partial word is dropped.
            if (stop_det) begin
                state_q   <= IDLE;
                busy_q    <= 1'b0;
                sda_drv_q <= 1'b0;
            end else if (start_det) begin
                if (state_q != IDLE) err_q <= 1'b1;
                state_q   <= ADDR;
                busy_q    <= 1'b1;
                bit_cnt_q <= 3'd0;
                sda_drv_q <= 1'b0;
            end else begin
                case (state_q)
                    ADDR, SUB, DATA: begin
                        if (scl_rise) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                case (state_q)
                                    ADDR: state_q <= (shift_d == WR_BYTE) ? ACK_A : IGNORE;
                                    SUB: begin
                                        sub_q   <= shift_d;
                                        state_q <= ACK_S;
                                    end
                                    default: begin
                                        if (commit_ok_d) begin
                                            wr_valid_q <= 1'b1;
                                            wr_addr_q  <= word_addr_d;
                                            wr_data_q  <= word_data_d;
                                            for (int i = 0; i < NUM_REGS; i++) begin
                                                if (word_addr_d == RESET_REG)
                                                    regs_q[i] <= 9'h000;
                                                else if (int'(word_addr_d) == i)
                                                    regs_q[i] <= word_data_d;
                                            end
                                            state_q <= ACK_D;
                                        end else begin
                                            err_q   <= 1'b1;
                                            state_q <= IGNORE;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                    // Entered on the 8th rising edge: the first falling edge
                    // starts the ACK pulse, the second one ends it.
                    ACK_A, ACK_S, ACK_D: begin
                        if (scl_fall) begin
                            if (!sda_drv_q) begin
                                sda_drv_q <= 1'b1;
                            end else begin
                                sda_drv_q <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                case (state_q)
                                    ACK_A:   state_q <= SUB;
                                    ACK_S:   state_q <= DATA;
                                    default: state_q <= IGNORE;
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [8:0] rd_data_d;

    always_comb begin
        rd_data_d = 9'h000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(host.rd_addr) == i) rd_data_d = regs_q[i];
        end
    end

    assign i2c_sdat      = sda_drv_q ? 1'b0 : 1'bz;
    assign host.wr_valid = wr_valid_q;
    assign host.wr_addr  = wr_addr_q;
    assign host.wr_data  = wr_data_q;
    assign host.rd_data  = rd_data_d;
    assign host.busy     = busy_q;
    assign host.err      = err_q;

endmodule

// File: tb/tb_i2c_codec_slave.sv
// ---------------------------------------------------------------------------
// tb_i2c_codec_slave
// Bit-banged I2C master driving the codec target, a transaction-level model
// of the register file, and a monitor that pops expected commits / errors
// from a scoreboard whenever the DUT strobes wr_valid or err.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_codec_slave;

    localparam int Q = 8;   // quarter SCL period in clk cycles
`ifdef I2C_SLV_FILTER_EN
    localparam int LAT = 5; // SCL rise driven -> wr_valid seen, in clk cycles
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic scl;
    logic m_sda_low;
    wire  sda;

    i2c_codec_slave_if hif ();

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_codec_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i2c_sclk (scl),
        .i2c_sdat (sda),
        .host     (hif.slave)
    );

    always #2.5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int err_exp  = 0;
    int last_rise_cyc = 0;
    logic [15:0] exp_q [$];
    logic [8:0]  mregs [16];
    logic [15:0] e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every DUT strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hif.wr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wr_unexpected: wr_valid addr=%0h data=%0h, none required",
                             hif.wr_addr, hif.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", hif.wr_addr, e[15:9]);
                    chk("wr_data", hif.wr_data, e[8:0]);
                    chk("commit_latency", cyc - last_rise_cyc, LAT);
                end
            end
            if (hif.err === 1'b1) begin
                n_checks++;
                if (err_exp == 0) begin
                    n_fail++;
                    $display("FAIL err_unexpected: err=1, required 0 (t=%0t)", $time);
                end else begin
                    err_exp--;
                end
            end
        end
    end

    task automatic wq(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wq(Q);
        scl = 1'b1;       wq(Q);
        m_sda_low = 1'b1; wq(Q);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wq(Q);
        scl = 1'b1;       wq(Q);
        m_sda_low = 1'b0; wq(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits, input bit is_data);
        for (int i = 7; i > 7 - nbits; i--) begin
            wq(Q);
            m_sda_low = ~b[i];
            wq(Q);
            if (is_data && i == 0) last_rise_cyc = cyc;
            scl = 1'b1;
            wq(2 * Q);
            scl = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_data, output logic ack);
        send_bits(b, 8, is_data);
        wq(Q);
        m_sda_low = 1'b0;
        wq(Q);
        scl = 1'b1;
        wq(Q);
        ack = (sda === 1'b0);
        wq(Q);
        scl = 1'b0;
    endtask

    // One write transaction; expectations come from the byte-level rules.
    task automatic do_write(input logic [7:0] a, input logic [7:0] s, input logic [7:0] d,
                            input bit fourth);
        logic       ack;
        bit         dev_ok, reg_ok;
        logic [6:0] ra;
        logic [8:0] rv;
        dev_ok = (a == 8'h34);
        ra     = s[7:1];
        rv     = {s[0], d};
        reg_ok = (ra < 7'd10) || (ra == 7'h0F);
        i2c_start();
        chk("busy_after_start", hif.busy, 1'b1);
        send_byte(a, 1'b0, ack);
        chk("ack_dev_addr", ack, dev_ok);
        if (!dev_ok) begin
            send_byte(s, 1'b0, ack);
            chk("ack_ignored_sub", ack, 1'b0);
            chk("busy_in_ignore", hif.busy, 1'b1);
            i2c_stop();
            chk("busy_after_stop", hif.busy, 1'b0);
            return;
        end
        send_byte(s, 1'b0, ack);
        chk("ack_sub", ack, 1'b1);
        if (reg_ok) exp_q.push_back({ra, rv});
        else        err_exp++;
        send_byte(d, 1'b1, ack);
        chk("ack_data", ack, reg_ok);
        if (reg_ok) begin
            if (ra == 7'h0F) for (int i = 0; i < 16; i++) mregs[i] = 9'h000;
            else             mregs[ra] = rv;
        end
        if (fourth) begin
            send_byte(8'($urandom), 1'b0, ack);
            chk("ack_fourth_byte", ack, 1'b0);
        end
        i2c_stop();
        chk("busy_after_stop", hif.busy, 1'b0);
    endtask

    task automatic readback(input int a);
        hif.rd_addr = 4'(a);
        #1;
        chk($sformatf("rd_data[%0d]", a), hif.rd_data, mregs[a]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack;
        for (int i = 0; i < 16; i++) mregs[i] = 9'h000;
        rst_n = 1'b0; scl = 1'b1; m_sda_low = 1'b0; hif.rd_addr = 4'd0;
        wq(5);
        chk("rst_wr_valid", hif.wr_valid, 1'b0);
        chk("rst_err", hif.err, 1'b0);
        chk("rst_busy", hif.busy, 1'b0);
        chk("rst_wr_addr", hif.wr_addr, 7'h00);
        chk("rst_wr_data", hif.wr_data, 9'h000);
        chk("rst_sda_released", sda, 1'b1);
        rst_n = 1'b1;
        wq(5);
        for (int i = 0; i < 16; i++) readback(i);

        // Directed writes from the codec's basic use.
        do_write(8'h34, 8'h08, 8'h12, 1'b0);
        wq(Q); readback(4);
        chk("reg4_value", hif.rd_data, 9'h012);
        do_write(8'h34, 8'h05, 8'h62, 1'b0);
        wq(Q); readback(2);
        chk("reg2_value", hif.rd_data, 9'h162);

        // Foreign device address and a read request are ignored.
        do_write(8'h36, 8'h08, 8'h55, 1'b0);
        do_write(8'h35, 8'h08, 8'h55, 1'b0);

        // Load, then clear via RESET_REG.
        do_write(8'h34, 8'h13, 8'hA5, 1'b0);
        do_write(8'h34, 8'h00, 8'h3C, 1'b0);
        wq(Q); for (int i = 0; i < 16; i++) readback(i);
        do_write(8'h34, 8'h1E, 8'h00, 1'b0);
        wq(Q); for (int i = 0; i < 16; i++) readback(i);

        // Out-of-range register, then a 4th byte after a good word.
        do_write(8'h34, 8'h16, 8'h77, 1'b0);
        do_write(8'h34, 8'h02, 8'h55, 1'b1);
        wq(Q); readback(1);

        // STOP right after the sub byte: nothing written.
        i2c_start();
        send_byte(8'h34, 1'b0, ack); chk("ack_dev_addr", ack, 1'b1);
        send_byte(8'h06, 1'b0, ack); chk("ack_sub", ack, 1'b1);
        i2c_stop();
        chk("busy_after_stop", hif.busy, 1'b0);

        // Repeated START in the middle of the data byte, then a full write.
        i2c_start();
        send_byte(8'h34, 1'b0, ack); chk("ack_dev_addr", ack, 1'b1);
        send_byte(8'h0C, 1'b0, ack); chk("ack_sub", ack, 1'b1);
        send_bits(8'hF0, 3, 1'b0);
        err_exp++;
        do_write(8'h34, 8'h0E, 8'h99, 1'b0);
        wq(Q); readback(7); readback(6);

        // Randomised traffic against the model.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] a, s;
            a = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h34;
            s = {3'($urandom_range(0, 7)), 5'($urandom)};
            if ($urandom_range(0, 1) == 0) s[7:1] = 7'($urandom_range(0, 15));
            do_write(a, s, 8'($urandom), ($urandom_range(0, 3) == 0));
            wq(Q);
            readback($urandom_range(0, 15));
        end

`ifdef I2C_SLV_FILTER_EN
        // 1-clk SDA glitch with SCL high must not look like START/STOP.
        m_sda_low = 1'b1; wq(1);
        m_sda_low = 1'b0; wq(2 * Q);
        chk("glitch_no_start", hif.busy, 1'b0);
        do_write(8'h34, 8'h10, 8'h3A, 1'b0);
        wq(Q); readback(8);
`endif

        // Asynchronous reset while the DUT is holding the ACK low.
        do_write(8'h34, 8'h12, 8'h81, 1'b0);
        i2c_start();
        send_bits(8'h34, 8, 1'b0);
        m_sda_low = 1'b0;
        wq(Q);
        chk("ack_driven_before_reset", sda, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("sda_released_by_reset", sda, 1'b1);
        chk("busy_in_reset", hif.busy, 1'b0);
        for (int i = 0; i < 16; i++) mregs[i] = 9'h000;
        wq(3);
        rst_n = 1'b1;
        i2c_stop();
        for (int i = 0; i < 16; i++) readback(i);
        do_write(8'h34, 8'h0A, 8'h5B, 1'b0);
        wq(Q); readback(5);

        wq(4 * Q);
        chk("pending_commits", exp_q.size(), 0);
        chk("pending_errors", err_exp, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
